// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and types for the UART transmit path:
//                data width, FIFO sizing defaults, baud divisor and the
//                transmitter state encoding.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned DATA_W            = 8;
    localparam int unsigned FIFO_DEPTH        = 16;
    localparam int unsigned FIFO_AFULL_LEVEL  = 12;

    localparam int unsigned CLK_HZ            = 1_000_000;
    localparam int unsigned BAUD              = 9600;
    // Integer divide: 104 clocks per bit, about 0.16 % fast, well inside
    // the tolerance of any UART receiver.
    localparam int unsigned UART_CLKS_PER_BIT = CLK_HZ / BAUD;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Pointer width carries one extra wrap bit beyond the address bits.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Bundle of the FIFO write side, status flags and the
//                first-word-fall-through read handshake.
//  Signals     : i_wr_data/i_wr_en/i_clr_ovf  write side (into FIFO)
//                o_full/o_afull/o_empty/o_level/o_overflow  status
//                o_data/o_valid/i_ready  read handshake toward transmitter
//  Modports    : slave  - the FIFO itself
//                master - the bus/CPU side and transmitter driving it
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int unsigned DEPTH = uart_pkg::FIFO_DEPTH
);
    import uart_pkg::*;

    localparam int unsigned LW = ptr_width(DEPTH);

    logic [DATA_W-1:0] i_wr_data;
    logic              i_wr_en;
    logic              i_clr_ovf;
    logic              o_full;
    logic              o_afull;
    logic              o_empty;
    logic [LW-1:0]     o_level;
    logic              o_overflow;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;

    modport slave (
        input  i_wr_data, i_wr_en, i_clr_ovf, i_ready,
        output o_full, o_afull, o_empty, o_level, o_overflow, o_data, o_valid
    );

    modport master (
        output i_wr_data, i_wr_en, i_clr_ovf, i_ready,
        input  o_full, o_afull, o_empty, o_level, o_overflow, o_data, o_valid
    );

endinterface : uart_tx_fifo_if
`default_nettype wire

// File: rtl/uart_tx_fifo_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 serial transmitter. Accepts a byte with a valid/ready
//                handshake while idle, then shifts out start bit, 8 data
//                bits LSB first and one stop bit.
//  Ports       : i_clk, i_rst (async, active-high)
//                i_data[7:0], i_valid   byte offered by the FIFO head
//                o_ready                high while idle (registered state)
//                o_tx                   serial line, idles high
//                o_busy                 frame in progress
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx,
    output logic              o_busy
);

    localparam int unsigned     CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;

    logic              cnt_end;
    logic [2:0]        bit_nxt;

    assign cnt_end = (cnt_q == CNT_LAST);
    assign bit_nxt = bit_q + 3'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // The line level for the next bit period is loaded together with the
    // state change, so o_tx comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (i_valid) begin
                    shreg_d = i_data;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cnt_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = shreg_q[bit_nxt];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (cnt_end) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign o_ready = (state_q == TX_IDLE);
    assign o_busy  = (state_q != TX_IDLE);
    assign o_tx    = tx_q;

endmodule : uart_tx
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : First-word-fall-through byte FIFO feeding a UART
//                transmitter. Register-array storage with one write port
//                and an asynchronous read port; status flags are decoded
//                from the registered pointers only.
//  Ports       : i_clk          clock, rising edge
//                i_rst          asynchronous active-high reset
//                bus (slave)    write side, status flags, read handshake
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = FIFO_DEPTH,       // power of two, 2..256
    parameter int unsigned AFULL_LEVEL = FIFO_AFULL_LEVEL
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_tx_fifo_if.slave bus
);

    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam int unsigned   PW        = AW + 1;
    localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          ovf_q, ovf_d;

    logic [PW-1:0] level_w;
    logic          full_w;
    logic          empty_w;
    logic          wr_acc_w;
    logic          wr_drop_w;
    logic          pop_w;

    // Wrap bit differs and address bits match: writer is one lap ahead.
    assign full_w  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_w = (wptr_q == rptr_q);
    // Modular difference of the extended pointers is the fill count.
    assign level_w = wptr_q - rptr_q;

    // full_w is registered-state only, so a same-cycle pop cannot rescue a
    // write presented while full.
    assign wr_acc_w  = bus.i_wr_en && !full_w;
    assign wr_drop_w = bus.i_wr_en &&  full_w;
    assign pop_w     = !empty_w && bus.i_ready;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        if (wr_acc_w) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_w) begin
            rptr_d = rptr_q + PW'(1);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (wr_drop_w) begin
            ovf_d = 1'b1;
        end else if (bus.i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage is deliberately outside reset: queued bytes are discarded by
    // clearing the pointers, and o_data is meaningless while o_valid=0.
    always_ff @(posedge i_clk) begin
        if (wr_acc_w) begin
            mem_q[wptr_q[AW-1:0]] <= bus.i_wr_data;
        end
    end

    assign bus.o_full     = full_w;
    assign bus.o_empty    = empty_w;
    assign bus.o_afull    = (level_w >= AFULL_THR);
    assign bus.o_level    = level_w;
    assign bus.o_overflow = ovf_q;
    assign bus.o_valid    = !empty_w;
    assign bus.o_data     = mem_q[rptr_q[AW-1:0]];

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo, with a
//                uart_tx instance for the end-to-end serial check.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFL   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    logic tb_ready;
    logic use_tx;
    logic tx_ready;
    logic tx_line;
    logic tx_busy;

    assign bus.i_ready = use_tx ? tx_ready : tb_ready;

    uart_tx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    uart_tx #(.CLKS_PER_BIT(UART_CLKS_PER_BIT)) u_tx (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (bus.o_data),
        .i_valid (bus.o_valid & use_tx),
        .o_ready (tx_ready),
        .o_tx    (tx_line),
        .o_busy  (tx_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.i_wr_data = b;
        bus.i_wr_en   = 1'b1;
        tick();
        bus.i_wr_en   = 1'b0;
    endtask

    // Pop n bytes one per cycle, expecting first, first+1, ...
    task automatic drain_expect(input string tag, input int n, input int first);
        tb_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
            check({tag, "_data"},  32'(bus.o_data),  32'((first + i) & 8'hFF));
            tick();
        end
        tb_ready = 1'b0;
        check({tag, "_empty"}, 32'(bus.o_empty), 32'd1);
    endtask

    task automatic rx_frame(input string tag, input logic [7:0] exp);
        int n;
        logic [7:0] b;
        n = 0;
        b = '0;
        while (tx_line !== 1'b0 && n < 5000) begin
            tick();
            n++;
        end
        check({tag, "_found"}, 32'(n < 5000), 32'd1);
        if (n < 5000) begin
            repeat (UART_CLKS_PER_BIT / 2) tick();
            check({tag, "_start"}, 32'(tx_line), 32'd0);
            for (int k = 0; k < 8; k++) begin
                repeat (UART_CLKS_PER_BIT) tick();
                b[k] = tx_line;
            end
            check({tag, "_byte"}, 32'(b), 32'(exp));
            repeat (UART_CLKS_PER_BIT) tick();
            check({tag, "_stop"}, 32'(tx_line), 32'd1);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] d;
        logic       we;
        int         sent;
        int         cyc;

        bus.i_wr_data = '0;
        bus.i_wr_en   = 1'b0;
        bus.i_clr_ovf = 1'b0;
        tb_ready      = 1'b0;
        use_tx        = 1'b0;
        rst           = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_empty", 32'(bus.o_empty),    32'd1);
        check("rst_valid", 32'(bus.o_valid),    32'd0);
        check("rst_full",  32'(bus.o_full),     32'd0);
        check("rst_afull", 32'(bus.o_afull),    32'd0);
        check("rst_level", 32'(bus.o_level),    32'd0);
        check("rst_ovf",   32'(bus.o_overflow), 32'd0);
        check("rst_line",  32'(tx_line),        32'd1);
        rst = 1'b0;
        tick();

        // Single byte, fall-through visible next cycle
        push(8'h55);
        check("t1_valid", 32'(bus.o_valid), 32'd1);
        check("t1_data",  32'(bus.o_data),  32'h55);
        check("t1_level", 32'(bus.o_level), 32'd1);
        tick();
        check("t1_hold",  32'(bus.o_data),  32'h55);
        drain_expect("t1_drain", 1, 8'h55);

        // Fill to full, almost-full threshold, overflow, clear priority
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            check("t2_afull", 32'(bus.o_afull), 32'((i + 1) >= 12));
            check("t2_full",  32'(bus.o_full),  32'(i == 15));
        end
        check("t2_level", 32'(bus.o_level),    32'd16);
        check("t2_ovf0",  32'(bus.o_overflow), 32'd0);
        push(8'hAA);
        check("t2_ovf1",  32'(bus.o_overflow), 32'd1);
        check("t2_lvl16", 32'(bus.o_level),    32'd16);
        bus.i_clr_ovf = 1'b1;
        push(8'hAA);
        check("t2_clrdrop", 32'(bus.o_overflow), 32'd1);
        tick();
        bus.i_clr_ovf = 1'b0;
        check("t2_clr",   32'(bus.o_overflow), 32'd0);
        drain_expect("t2_drain", 16, 0);

        // Simultaneous write and pop at levels 1, 8 and 16
        push(8'h10);
        bus.i_wr_data = 8'h11; bus.i_wr_en = 1'b1; tb_ready = 1'b1;
        tick();
        bus.i_wr_en = 1'b0; tb_ready = 1'b0;
        check("t3_l1_level", 32'(bus.o_level), 32'd1);
        check("t3_l1_data",  32'(bus.o_data),  32'h11);
        drain_expect("t3_l1_drain", 1, 8'h11);
        for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
        bus.i_wr_data = 8'h28; bus.i_wr_en = 1'b1; tb_ready = 1'b1;
        tick();
        bus.i_wr_en = 1'b0; tb_ready = 1'b0;
        check("t3_l8_level", 32'(bus.o_level), 32'd8);
        check("t3_l8_data",  32'(bus.o_data),  32'h21);
        for (int i = 0; i < 8; i++) push(8'(8'h29 + i));
        check("t3_l16_full", 32'(bus.o_full), 32'd1);
        bus.i_wr_data = 8'hEE; bus.i_wr_en = 1'b1; tb_ready = 1'b1;
        tick();
        bus.i_wr_en = 1'b0; tb_ready = 1'b0;
        check("t3_l16_level", 32'(bus.o_level),    32'd15);
        check("t3_l16_ovf",   32'(bus.o_overflow), 32'd1);
        drain_expect("t3_l16_drain", 15, 8'h22);
        bus.i_clr_ovf = 1'b1; tick(); bus.i_clr_ovf = 1'b0;

        // Random ready, 40 writes across pointer wraps, scoreboarded
        sent = 0;
        cyc  = 0;
        while ((sent < 40 || q.size() != 0) && cyc < 3000) begin
            check("t4_valid", 32'(bus.o_valid), 32'(q.size() != 0));
            check("t4_level", 32'(bus.o_level), 32'(q.size()));
            tb_ready = 1'($urandom_range(0, 1));
            we = (sent < 40) && !bus.o_full && ($urandom_range(0, 3) != 0);
            d  = 8'($urandom_range(0, 255));
            bus.i_wr_en   = we;
            bus.i_wr_data = d;
            if (bus.o_valid && tb_ready) begin
                check("t4_data", 32'(bus.o_data), 32'(q[0]));
                void'(q.pop_front());
            end
            if (we) begin
                q.push_back(d);
                sent++;
            end
            tick();
            cyc++;
        end
        bus.i_wr_en = 1'b0;
        tb_ready    = 1'b0;
        check("t4_budget", 32'(cyc < 3000), 32'd1);
        check("t4_sent",   32'(sent),       32'd40);
        check("t4_ovf",    32'(bus.o_overflow), 32'd0);

        // Asynchronous reset mid-clock with 5 entries and overflow pending
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        push(8'h99);
        tb_ready = 1'b1;
        repeat (11) tick();
        tb_ready = 1'b0;
        check("t5_pre_level", 32'(bus.o_level),    32'd5);
        check("t5_pre_ovf",   32'(bus.o_overflow), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_empty", 32'(bus.o_empty),    32'd1);
        check("t5_valid", 32'(bus.o_valid),    32'd0);
        check("t5_level", 32'(bus.o_level),    32'd0);
        check("t5_ovf",   32'(bus.o_overflow), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        push(8'h5A);
        check("t5_resume_data",  32'(bus.o_data),  32'h5A);
        check("t5_resume_level", 32'(bus.o_level), 32'd1);
        drain_expect("t5_drain", 1, 8'h5A);

        // End to end through the serial transmitter
        use_tx = 1'b1;
        push(8'h48);
        push(8'h69);
        rx_frame("t6_f0", 8'h48);
        rx_frame("t6_f1", 8'h69);
        repeat (UART_CLKS_PER_BIT) tick();
        check("t6_idle",  32'(tx_busy),     32'd0);
        check("t6_line",  32'(tx_line),     32'd1);
        check("t6_empty", 32'(bus.o_empty), 32'd1);
        use_tx = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx_fifo
`default_nettype wire
